// File: rtl/dmem_access_unit_if.sv
// Request/response and SRAM bus of the data-memory access unit.
// slave  : the access unit itself.
// master : the MEM stage plus the SRAM (the environment around the unit).
interface dmem_access_unit_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int DM_MEM_DEPTH = 4096
);
    localparam int AW = $clog2(DM_MEM_DEPTH);

    logic                  memRead;
    logic                  memWrite;
    logic [2:0]            func3;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;
    logic                  err;
    logic                  mem_en;
    logic [3:0]            mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  memRead, memWrite, func3, addr, wdata, mem_rdata,
        output rdata, ready, err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output memRead, memWrite, func3, addr, wdata, mem_rdata,
        input  rdata, ready, err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns MEM-stage load/store requests into
// accesses on a synchronous word SRAM and returns an extended load result
// with a one-cycle ready pulse. FSM: IDLE -> ACCESS (WAIT_CYCLES) -> RESP.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned H/HU/W accesses fault
// instead of being silently force-aligned.
module dmem_access_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int DM_MEM_DEPTH = 4096,
    parameter int WAIT_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_access_unit_if.slave     bus
);
    localparam int         AW        = $clog2(DM_MEM_DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state;
    logic [3:0]            waitCnt;
    logic                  opStore;
    logic                  opFault;
    logic [2:0]            opFunc3;
    logic [1:0]            opOffset;
    logic [DATA_WIDTH-1:0] rdataHold;
    logic                  readyReg;
    logic                  errReg;
    logic                  memEnReg;
    logic [3:0]            memWeReg;
    logic [AW-1:0]         memAddrReg;
    logic [DATA_WIDTH-1:0] memWdataReg;

    logic                  reqFault;
    logic [1:0]            reqOffset;
    logic [3:0]            reqLanes;
    logic [DATA_WIDTH-1:0] reqWdata;
    logic [DATA_WIDTH-1:0] laneData;
    logic [DATA_WIDTH-1:0] loadData;

    // Address bits above the SRAM index wrap and are intentionally dropped.
    logic unusedAddrBits;
    assign unusedAddrBits = ^bus.addr[DATA_WIDTH-1:AW+2];

    // Decode the incoming request: size, byte lanes, replicated store data, fault.
    always_comb begin
        reqFault  = 1'b0;
        reqOffset = bus.addr[1:0];
        reqLanes  = 4'b0000;
        reqWdata  = bus.wdata;
        case (bus.func3[1:0])
            2'b00: begin
                reqLanes = 4'b0001 << reqOffset;
                reqWdata = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                // Halfword lives in the lower or upper half; addr[0] is dropped.
                reqOffset = {bus.addr[1], 1'b0};
                reqLanes  = 4'b0011 << reqOffset;
                reqWdata  = {2{bus.wdata[15:0]}};
`ifdef DMEM_MISALIGN_TRAP_EN
                reqFault  = bus.addr[0];
`endif
            end
            2'b10: begin
                reqOffset = 2'b00;
                reqLanes  = 4'b1111;
`ifdef DMEM_MISALIGN_TRAP_EN
                reqFault  = (bus.addr[1:0] != 2'b00);
`endif
            end
            default: reqFault = 1'b1;
        endcase
        // Only B/H/W/BU/HU exist; unsigned forms make no sense for stores.
        if (bus.func3 == 3'b110 || bus.func3 == 3'b111)
            reqFault = 1'b1;
        if (bus.memWrite && bus.func3[2])
            reqFault = 1'b1;
    end

    // Select the addressed lane of the SRAM word and sign/zero extend it.
    always_comb begin
        laneData = bus.mem_rdata >> {opOffset, 3'b000};
        case (opFunc3)
            3'b000:  loadData = {{24{laneData[7]}}, laneData[7:0]};
            3'b001:  loadData = {{16{laneData[15]}}, laneData[15:0]};
            3'b100:  loadData = {24'd0, laneData[7:0]};
            3'b101:  loadData = {16'd0, laneData[15:0]};
            default: loadData = laneData;
        endcase
    end

    // Access FSM with registered SRAM controls and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            waitCnt     <= '0;
            opStore     <= 1'b0;
            opFault     <= 1'b0;
            opFunc3     <= '0;
            opOffset    <= '0;
            rdataHold   <= '0;
            readyReg    <= 1'b0;
            errReg      <= 1'b0;
            memEnReg    <= 1'b0;
            memWeReg    <= 4'b0000;
            memAddrReg  <= '0;
            memWdataReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.memRead || bus.memWrite) begin
                        state       <= ACCESS;
                        waitCnt     <= WAIT_LOAD;
                        opStore     <= bus.memWrite;
                        opFault     <= reqFault;
                        opFunc3     <= bus.func3;
                        opOffset    <= reqOffset;
                        memEnReg    <= !reqFault;
                        memWeReg    <= (bus.memWrite && !reqFault) ? reqLanes : 4'b0000;
                        memAddrReg  <= bus.addr[AW+1:2];
                        memWdataReg <= reqWdata;
                    end
                end
                ACCESS: begin
                    memEnReg <= 1'b0;
                    memWeReg <= 4'b0000;
                    if (waitCnt == 4'd0) begin
                        state    <= RESP;
                        readyReg <= 1'b1;
                        errReg   <= opFault;
                        if (opFault)
                            rdataHold <= '0;
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                RESP: begin
                    // Always back to IDLE so the still-held request is not taken twice.
                    state    <= IDLE;
                    readyReg <= 1'b0;
                    errReg   <= 1'b0;
                    if (!opStore && !opFault)
                        rdataHold <= loadData;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // mem_rdata is already the SRAM's output register; during RESP of a good
    // load it is shaped directly, afterwards the captured copy is held.
    assign bus.rdata     = (state == RESP && !opStore && !opFault) ? loadData : rdataHold;
    assign bus.ready     = readyReg;
    assign bus.err       = errReg;
    assign bus.mem_en    = memEnReg;
    assign bus.mem_we    = memWeReg;
    assign bus.mem_addr  = memAddrReg;
    assign bus.mem_wdata = memWdataReg;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: a WAIT_CYCLES=1 and a WAIT_CYCLES=3
// instance, each with its own synchronous SRAM model (64 words).
module tb_dmem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;     // 0: drive/observe u1, 1: u3
    logic        memRead = 1'b0, memWrite = 1'b0;
    logic [2:0]  func3 = '0;
    logic [31:0] addr = '0, wdata = '0;

    int checks = 0;
    int errors = 0;

    dmem_access_unit_if #(.DATA_WIDTH(32), .DM_MEM_DEPTH(64)) b1 ();
    dmem_access_unit_if #(.DATA_WIDTH(32), .DM_MEM_DEPTH(64)) b3 ();

    dmem_access_unit #(.DATA_WIDTH(32), .DM_MEM_DEPTH(64), .WAIT_CYCLES(1))
        u1 (.clk(clk), .rst(rst), .bus(b1));
    dmem_access_unit #(.DATA_WIDTH(32), .DM_MEM_DEPTH(64), .WAIT_CYCLES(3))
        u3 (.clk(clk), .rst(rst), .bus(b3));

    assign b1.memRead  = memRead & ~sel;
    assign b1.memWrite = memWrite & ~sel;
    assign b1.func3    = func3;
    assign b1.addr     = addr;
    assign b1.wdata    = wdata;
    assign b3.memRead  = memRead & sel;
    assign b3.memWrite = memWrite & sel;
    assign b3.func3    = func3;
    assign b3.addr     = addr;
    assign b3.wdata    = wdata;

    // SRAM models: byte-enable write, read-before-write, output held between reads.
    logic [31:0] mem1 [0:63];
    logic [31:0] mem3 [0:63];
    always @(posedge clk) begin
        if (b1.mem_en) begin
            b1.mem_rdata <= mem1[b1.mem_addr];
            for (int i = 0; i < 4; i++)
                if (b1.mem_we[i]) mem1[b1.mem_addr][8*i +: 8] <= b1.mem_wdata[8*i +: 8];
        end
    end
    always @(posedge clk) begin
        if (b3.mem_en) begin
            b3.mem_rdata <= mem3[b3.mem_addr];
            for (int j = 0; j < 4; j++)
                if (b3.mem_we[j]) mem3[b3.mem_addr][8*j +: 8] <= b3.mem_wdata[8*j +: 8];
        end
    end

    logic        sRdy, sErr, sEn;
    logic [3:0]  sWe;
    logic [5:0]  sMa;
    logic [31:0] sMwd, sRdata;
    assign sRdy   = sel ? b3.ready     : b1.ready;
    assign sErr   = sel ? b3.err       : b1.err;
    assign sEn    = sel ? b3.mem_en    : b1.mem_en;
    assign sWe    = sel ? b3.mem_we    : b1.mem_we;
    assign sMa    = sel ? b3.mem_addr  : b1.mem_addr;
    assign sMwd   = sel ? b3.mem_wdata : b1.mem_wdata;
    assign sRdata = sel ? b3.rdata     : b1.rdata;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    // Called at a negedge. Holds the request through the RESP cycle, then drops it.
    task automatic runAcc(input logic s, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rdv, output logic e, output logic [3:0] weSeen,
                          output int enCnt, output logic [5:0] ma, output logic [31:0] mwd,
                          output int lat, output logic extra, output logic [31:0] rdHold);
        sel = s; memRead = rd; memWrite = wr; func3 = f3; addr = a; wdata = wd;
        lat = 0; enCnt = 0; weSeen = '0; ma = '0; mwd = '0;
        do begin
            @(negedge clk);
            lat++;
            if (sEn) begin enCnt++; ma = sMa; mwd = sMwd; end
            weSeen |= sWe;
        end while (!sRdy && lat < 40);
        rdv = sRdata;
        e   = sErr;
        @(negedge clk);
        extra  = sRdy | sEn;
        rdHold = sRdata;
        memRead = 1'b0; memWrite = 1'b0;
    endtask

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a, wd, expRdata;
        logic        expErr;
        int          expEn;
        logic [3:0]  expWe;
        logic [5:0]  expMa;
        logic [31:0] expMwd;
    } vec_t;

    vec_t vecs [0:19];
    int   nVec;

    initial begin
        logic [31:0] rdv, mwd, rdHold;
        logic        e, extra;
        logic [3:0]  we;
        logic [5:0]  ma;
        int          enCnt, lat, cnt;

        for (int k = 0; k < 64; k++) begin mem1[k] = '0; mem3[k] = '0; end

        //                rd  wr  f3      addr        wdata         rdata        err en we       ma     mwd
        vecs[0]  = '{1'b0,1'b1,3'b010,32'h10, 32'hDEADBEEF,32'h00000000,1'b0,1,4'b1111,6'd4,32'hDEADBEEF};
        vecs[1]  = '{1'b1,1'b0,3'b010,32'h10, 32'h0,       32'hDEADBEEF,1'b0,1,4'b0000,6'd4,32'h0};
        vecs[2]  = '{1'b0,1'b1,3'b010,32'h10, 32'h80FF7F01,32'hDEADBEEF,1'b0,1,4'b1111,6'd4,32'h80FF7F01};
        vecs[3]  = '{1'b1,1'b0,3'b000,32'h13, 32'h0,       32'hFFFFFF80,1'b0,1,4'b0000,6'd4,32'h0};
        vecs[4]  = '{1'b1,1'b0,3'b100,32'h13, 32'h0,       32'h00000080,1'b0,1,4'b0000,6'd4,32'h0};
        vecs[5]  = '{1'b1,1'b0,3'b001,32'h12, 32'h0,       32'hFFFF80FF,1'b0,1,4'b0000,6'd4,32'h0};
        vecs[6]  = '{1'b1,1'b0,3'b101,32'h10, 32'h0,       32'h00007F01,1'b0,1,4'b0000,6'd4,32'h0};
        vecs[7]  = '{1'b0,1'b1,3'b010,32'h20, 32'h11223344,32'h00007F01,1'b0,1,4'b1111,6'd8,32'h11223344};
        vecs[8]  = '{1'b0,1'b1,3'b000,32'h21, 32'h000000AB,32'h00007F01,1'b0,1,4'b0010,6'd8,32'hABABABAB};
        vecs[9]  = '{1'b1,1'b0,3'b010,32'h20, 32'h0,       32'h1122AB44,1'b0,1,4'b0000,6'd8,32'h0};
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs[10] = '{1'b1,1'b0,3'b010,32'h22, 32'h0,       32'h00000000,1'b1,0,4'b0000,6'd0,32'h0};
`else
        vecs[10] = '{1'b1,1'b0,3'b010,32'h22, 32'h0,       32'h1122AB44,1'b0,1,4'b0000,6'd8,32'h0};
`endif
        vecs[11] = '{1'b1,1'b0,3'b010,32'h120,32'h0,       32'h1122AB44,1'b0,1,4'b0000,6'd8,32'h0};
        vecs[12] = '{1'b1,1'b0,3'b011,32'h20, 32'h0,       32'h00000000,1'b1,0,4'b0000,6'd0,32'h0};
        vecs[13] = '{1'b0,1'b1,3'b100,32'h20, 32'hFFFFFFFF,32'h00000000,1'b1,0,4'b0000,6'd0,32'h0};
        vecs[14] = '{1'b1,1'b0,3'b010,32'h20, 32'h0,       32'h1122AB44,1'b0,1,4'b0000,6'd8,32'h0};
        vecs[15] = '{1'b0,1'b1,3'b001,32'h26, 32'h0000BEEF,32'h1122AB44,1'b0,1,4'b1100,6'd9,32'hBEEFBEEF};
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs[16] = '{1'b1,1'b0,3'b001,32'h27, 32'h0,       32'h00000000,1'b1,0,4'b0000,6'd0,32'h0};
`else
        vecs[16] = '{1'b1,1'b0,3'b001,32'h27, 32'h0,       32'hFFFFBEEF,1'b0,1,4'b0000,6'd9,32'h0};
`endif
        vecs[17] = '{1'b1,1'b0,3'b001,32'h26, 32'h0,       32'hFFFFBEEF,1'b0,1,4'b0000,6'd9,32'h0};
        vecs[18] = '{1'b1,1'b0,3'b101,32'h26, 32'h0,       32'h0000BEEF,1'b0,1,4'b0000,6'd9,32'h0};
        nVec = 19;

        // Reset state of both instances
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_u1_ready", {31'd0, b1.ready}, 32'd0);
        chk("rst_u1_err",   {31'd0, b1.err},   32'd0);
        chk("rst_u1_en",    {31'd0, b1.mem_en}, 32'd0);
        chk("rst_u1_we",    {28'd0, b1.mem_we}, 32'd0);
        chk("rst_u1_rdata", b1.rdata, 32'd0);
        chk("rst_u3_ready", {31'd0, b3.ready}, 32'd0);
        chk("rst_u3_rdata", b3.rdata, 32'd0);

        // Table vectors on the WAIT_CYCLES=1 instance
        for (int v = 0; v < nVec; v++) begin
            runAcc(1'b0, vecs[v].rd, vecs[v].wr, vecs[v].f3, vecs[v].a, vecs[v].wd,
                   rdv, e, we, enCnt, ma, mwd, lat, extra, rdHold);
            chk($sformatf("lat[%0d]", v),    lat, 32'd2);
            chk($sformatf("rdata[%0d]", v),  rdv, vecs[v].expRdata);
            chk($sformatf("err[%0d]", v),    {31'd0, e}, {31'd0, vecs[v].expErr});
            chk($sformatf("enCnt[%0d]", v),  enCnt, vecs[v].expEn);
            chk($sformatf("we[%0d]", v),     {28'd0, we}, {28'd0, vecs[v].expWe});
            chk($sformatf("single[%0d]", v), {31'd0, extra}, 32'd0);
            chk($sformatf("hold[%0d]", v),   rdHold, vecs[v].expRdata);
            if (vecs[v].expEn != 0)
                chk($sformatf("maddr[%0d]", v), {26'd0, ma}, {26'd0, vecs[v].expMa});
            if (vecs[v].expEn != 0 && vecs[v].wr)
                chk($sformatf("mwdata[%0d]", v), mwd, vecs[v].expMwd);
        end

        // WAIT_CYCLES=3: read+write together, store wins, single ready at T+4
        runAcc(1'b1, 1'b1, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D,
               rdv, e, we, enCnt, ma, mwd, lat, extra, rdHold);
        chk("w3_lat",    lat, 32'd4);
        chk("w3_we",     {28'd0, we}, 32'h0000000F);
        chk("w3_enCnt",  enCnt, 32'd1);
        chk("w3_maddr",  {26'd0, ma}, 32'd12);
        chk("w3_mwdata", mwd, 32'hCAFEF00D);
        chk("w3_rdata",  rdv, 32'd0);
        chk("w3_single", {31'd0, extra}, 32'd0);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (b3.ready || b3.mem_en) cnt++;
        end
        chk("w3_noReaccept", cnt, 32'd0);
        runAcc(1'b1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0,
               rdv, e, we, enCnt, ma, mwd, lat, extra, rdHold);
        chk("w3_ld_lat",   lat, 32'd4);
        chk("w3_ld_rdata", rdv, 32'hCAFEF00D);
        chk("w3_ld_we",    {28'd0, we}, 32'd0);

        // Reset during ACCESS aborts the load with no ready pulse
        sel = 1'b0; memRead = 1'b1; func3 = 3'b010; addr = 32'h10;
        @(negedge clk);
        chk("abort_inAccess", {31'd0, b1.mem_en}, 32'd1);
        rst = 1'b1; memRead = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'd0, b1.ready},  32'd0);
        chk("abort_err",   {31'd0, b1.err},    32'd0);
        chk("abort_en",    {31'd0, b1.mem_en}, 32'd0);
        chk("abort_we",    {28'd0, b1.mem_we}, 32'd0);
        chk("abort_rdata", b1.rdata, 32'd0);
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (b1.ready) cnt++;
        end
        chk("abort_noReady", cnt, 32'd0);
        runAcc(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0,
               rdv, e, we, enCnt, ma, mwd, lat, extra, rdHold);
        chk("recover_lat",   lat, 32'd2);
        chk("recover_rdata", rdv, 32'h80FF7F01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data/address width; only 32 supported.
REQ-002 SHALL have parameter DM_MEM_DEPTH, default 4096: SRAM depth in 32-bit words; power of two.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1: SRAM read latency in cycles; legal range 1..15.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port memRead, input, 1: load request from the MEM stage.
REQ-007 SHALL have port memWrite, input, 1: store request from the MEM stage.
REQ-008 SHALL have port func3, input, 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 SHALL have port addr, input, 32: byte address (MEM-stage ALU result).
REQ-010 SHALL have port wdata, input, 32: store data, right-aligned.
REQ-011 SHALL have port rdata, output, 32: extended load data to MEM/WB.
REQ-012 SHALL have port ready, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1: access fault, valid while ready=1.
REQ-014 SHALL have ports mem_en (output, 1), mem_we (output, 4), mem_addr (output, log2(DM_MEM_DEPTH)), mem_wdata (output, 32), mem_rdata (input, 32): synchronous word SRAM.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-016 SHALL, in IDLE, accept a request when memRead|memWrite=1 and latch addr, func3, wdata, op.
REQ-017 SHALL give memWrite precedence when memRead and memWrite are both 1.
REQ-018 SHALL stay in ACCESS exactly WAIT_CYCLES cycles, via a down-counter reloaded on acceptance.
REQ-019 SHALL assert mem_en only in the first ACCESS cycle, with mem_addr = latched addr[log2(DM_MEM_DEPTH)+1:2]; upper address bits ignored (wrap).
REQ-020 SHALL, for stores, drive mem_we = byte lanes (B: 1 lane, H: 2 lanes, W: 4 lanes) shifted by addr[1:0], with wdata replicated into each lane; mem_we=0 for loads.
REQ-021 SHALL hold ready=1 for exactly one cycle in RESP, i.e. request accepted at cycle T -> ready at T+1+WAIT_CYCLES.
REQ-022 SHALL register rdata on entry to RESP from mem_rdata: lane selected by addr[1:0]; B/H sign-extended, BU/HU zero-extended, W unchanged; rdata held until the next load completes.
REQ-023 SHALL leave rdata unchanged on store completion.
REQ-024 SHALL treat an unsupported func3 (011, 110, 111, any store with func3[2]=1) as a fault: no mem_en, no mem_we, same latency, err=1, rdata=0.
REQ-025 SHALL always return RESP -> IDLE, so the still-asserted request in the RESP cycle is not re-accepted.
REQ-026 SHALL never accept a request outside IDLE; callers hold inputs stable until ready.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, enter IDLE, clear counter, rdata=0, ready=0, err=0, mem_en=0, mem_we=0, in the following cycle.
REQ-028 SHALL abort an in-flight access on rst without completion; no ready pulse for it.

Configuration
REQ-029 SHALL support macro DMEM_MISALIGN_TRAP_EN.
REQ-030 SHALL, with DMEM_MISALIGN_TRAP_EN defined, treat H/HU with addr[0]=1 or W with addr[1:0]!=0 as a fault per REQ-024.
REQ-031 SHALL, without DMEM_MISALIGN_TRAP_EN, force alignment (H: addr[0] ignored; W: addr[1:0] ignored) with err=0.

Verification
REQ-032 SHALL cover: WAIT_CYCLES=1, SW addr=0x10 wdata=0xDEADBEEF then LW addr=0x10 -> mem_we=1111 at word 4; ready at T+2; rdata=0xDEADBEEF.
REQ-033 SHALL cover: word 4=0x80FF7F01; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; LHU 0x10 -> 0x00007F01.
REQ-034 SHALL cover: SB addr=0x21 wdata=0x000000AB -> mem_we=0010, mem_wdata=0xABABABAB; neighbouring bytes unchanged.
REQ-035 SHALL cover: WAIT_CYCLES=3, memRead and memWrite both 1 -> store performed; ready exactly at T+4; single pulse; no re-accept in RESP cycle.
REQ-036 SHALL cover: LW addr=0x22 -> with macro err=1, mem_en never 1, rdata=0; without macro rdata = word 8, err=0.
REQ-037 SHALL cover: rst asserted in the ACCESS cycle -> IDLE next cycle, all outputs 0, no ready pulse.
